// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU pipeline stages: operator encodings,
// field widths and the alignment FSM state type.
package fpu_pkg;
  localparam int EXP_W           = 8;
  localparam int MANT_W          = 24;
  localparam int GRS_W           = 3;
  localparam int ALIGN_W         = MANT_W + GRS_W;  // 27
  localparam int MAX_ALIGN_SHIFT = 27;
  localparam int CNT_W           = 5;               // holds 0..MAX_ALIGN_SHIFT

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_t;
endpackage

// File: rtl/fpu_sticky_shift.sv
// Combinational right shift by n with every bit shifted out ORed into bit 0
// (sticky). n == 0 passes the value through unchanged.
module fpu_sticky_shift
  import fpu_pkg::*;
(
  input  logic [ALIGN_W-1:0] work,
  input  logic [CNT_W-1:0]   n,
  output logic [ALIGN_W-1:0] shifted
);
  logic [ALIGN_W:0]   mask_ext;
  logic [ALIGN_W-1:0] lost_mask;
  logic               sticky;

  // Mask the low n bits (one bit wider so n == ALIGN_W yields all ones),
  // reduce them to a sticky bit and merge into the shifted value.
  always_comb begin
    mask_ext  = ((ALIGN_W+1)'(1) << n) - (ALIGN_W+1)'(1);
    lost_mask = mask_ext[ALIGN_W-1:0];
    sticky    = |(work & lost_mask);
    shifted   = work >> n;
    shifted[0] = shifted[0] | sticky;
  end
endmodule

// File: rtl/fpu_align.sv
// Exponent alignment stage: right-shifts the smaller mantissa by the exponent
// difference (saturated at 27) in SHIFT_STEP-bit chunks, keeping G/R/S bits.
// Mul/div bypass the shift. Valid/ready handshake on both sides.
// Optional build macro FPU_ALIGN_EARLY_EXIT_EN: a full-width (27) shift
// resolves on the accept edge instead of iterating; results are identical.
module fpu_align
  import fpu_pkg::*;
#(
  parameter int SHIFT_STEP = 4  // 1..27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sign_1,
  input  logic               sign_2,
  input  logic [EXP_W-1:0]   exponent_1,
  input  logic [EXP_W-1:0]   exponent_2,
  input  logic [MANT_W-1:0]  mantissa_1,
  input  logic [MANT_W-1:0]  mantissa_2,
  input  logic [1:0]         operator,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign_1,
  output logic               out_sign_2,
  output logic [EXP_W-1:0]   out_exponent,
  output logic [EXP_W-1:0]   out_exponent_2,
  output logic [ALIGN_W-1:0] out_mantissa_1,
  output logic [ALIGN_W-1:0] out_mantissa_2,
  output logic [1:0]         out_operator
);
  localparam logic [CNT_W-1:0] STEP    = CNT_W'(SHIFT_STEP);
  localparam logic [CNT_W-1:0] SAT_MAX = CNT_W'(MAX_ALIGN_SHIFT);

  align_state_t       state;
  logic [CNT_W-1:0]   remaining;
  logic [ALIGN_W-1:0] work;
  logic [ALIGN_W-1:0] work_shifted;
  logic [EXP_W-1:0]   diff;
  logic [CNT_W-1:0]   d_init;
  logic [CNT_W-1:0]   step;

  logic               s1_q, s2_q;
  logic [EXP_W-1:0]   e1_q, e2_q;
  logic [MANT_W-1:0]  m1_q;
  logic [1:0]         op_q;

  // Saturated shift amount for the incoming operands; mul/div never shift.
  always_comb begin
    diff   = exponent_1 - exponent_2;
    d_init = (diff > EXP_W'(MAX_ALIGN_SHIFT)) ? SAT_MAX : diff[CNT_W-1:0];
    if (operator[1]) d_init = '0;
    step   = (remaining > STEP) ? STEP : remaining;
  end

  fpu_sticky_shift u_shift (
    .work    (work),
    .n       (step),
    .shifted (work_shifted)
  );

  // Handshake FSM: capture on accept, iterate the shifter, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      work      <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      e1_q      <= '0;
      e2_q      <= '0;
      m1_q      <= '0;
      op_q      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          s1_q      <= sign_1;
          s2_q      <= sign_2;
          e1_q      <= exponent_1;
          e2_q      <= exponent_2;
          m1_q      <= mantissa_1;
          op_q      <= operator;
          work      <= {mantissa_2, {GRS_W{1'b0}}};
          remaining <= d_init;
`ifdef FPU_ALIGN_EARLY_EXIT_EN
          if (d_init == SAT_MAX) begin
            // Everything falls off the end: only the sticky bit survives.
            work      <= {{(ALIGN_W-1){1'b0}}, |mantissa_2};
            remaining <= '0;
            state     <= DONE;
          end else begin
            state <= (d_init == '0) ? DONE : SHIFT;
          end
`else
          state <= (d_init == '0) ? DONE : SHIFT;
`endif
        end
        SHIFT: begin
          work      <= work_shifted;
          remaining <= remaining - step;
          if (remaining == step) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready       = (state == IDLE);
  assign out_valid      = (state == DONE);
  assign out_sign_1     = s1_q;
  assign out_sign_2     = s2_q;
  assign out_exponent   = e1_q;
  assign out_exponent_2 = e2_q;
  assign out_mantissa_1 = {m1_q, {GRS_W{1'b0}}};
  assign out_mantissa_2 = work;
  assign out_operator   = op_q;
endmodule

// File: tb/tb_fpu_align.sv
// Self-checking bench for fpu_align: directed vector table, backpressure and
// mid-shift reset sequences, then randomized operands against a reference
// model built from plain arithmetic on the exponent difference.
module tb_fpu_align;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_1 = 1'b0, sign_2 = 1'b0;
  logic [7:0]  exponent_1 = '0, exponent_2 = '0;
  logic [23:0] mantissa_1 = '0, mantissa_2 = '0;
  logic [1:0]  operator = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign_1, out_sign_2;
  logic [7:0]  out_exponent, out_exponent_2;
  logic [26:0] out_mantissa_1, out_mantissa_2;
  logic [1:0]  out_operator;

  int errors = 0;
  int checks = 0;

  fpu_align #(.SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign_1(sign_1), .sign_2(sign_2), .exponent_1(exponent_1), .exponent_2(exponent_2),
    .mantissa_1(mantissa_1), .mantissa_2(mantissa_2), .operator(operator),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign_1(out_sign_1),
    .out_sign_2(out_sign_2), .out_exponent(out_exponent), .out_exponent_2(out_exponent_2),
    .out_mantissa_1(out_mantissa_1), .out_mantissa_2(out_mantissa_2),
    .out_operator(out_operator)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact right shift of {m2,000} by the saturated difference,
  // with a sticky 1 whenever any nonzero bits were lost.
  function automatic logic [26:0] ref_align(input logic [23:0] m2, input logic [7:0] e1,
                                            input logic [7:0] e2, input logic [1:0] op);
    longint unsigned v, lost;
    int d;
    v = longint'(m2) * 8;
    d = int'(e1) - int'(e2);
    if (d > 27) d = 27;
    if (op >= 2) d = 0;
    if (d == 0) return 27'(v);
    lost = v % (64'd1 << d);
    return 27'((v >> d) + ((lost != 0 && ((v >> d) % 2 == 0)) ? 1 : 0));
  endfunction

  function automatic int ref_lat(input logic [7:0] e1, input logic [7:0] e2, input logic [1:0] op);
    int d;
    d = int'(e1) - int'(e2);
    if (d > 27) d = 27;
    if (op >= 2 || d == 0) return 1;
`ifdef FPU_ALIGN_EARLY_EXIT_EN
    if (d == 27) return 1;
`endif
    return 1 + (d + STEP - 1) / STEP;
  endfunction

  // One full transaction: accept, measure latency, check fields, optional
  // hold under backpressure, then transfer.
  task automatic run_op(input string tag, input logic s1, input logic s2,
                        input logic [7:0] e1, input logic [7:0] e2,
                        input logic [23:0] m1, input logic [23:0] m2, input logic [1:0] op,
                        input logic [26:0] exp_m2, input int exp_lat, input int hold);
    int w, lat;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk({tag, " in_ready"}, in_ready, 1);
    sign_1 = s1; sign_2 = s2; exponent_1 = e1; exponent_2 = e2;
    mantissa_1 = m1; mantissa_2 = m2; operator = op; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " mant2"}, out_mantissa_2, exp_m2);
    chk({tag, " mant1"}, out_mantissa_1, {m1, 3'b000});
    chk({tag, " exp"}, out_exponent, e1);
    chk({tag, " exp2"}, out_exponent_2, e2);
    chk({tag, " signs_op"}, {out_sign_1, out_sign_2, out_operator}, {s1, s2, op});
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({tag, " held"}, {out_valid, out_mantissa_2}, {1'b1, exp_m2});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " after_xfer"}, {out_valid, in_ready}, 2'b01);
  endtask

  typedef struct {
    logic [7:0]  e1, e2;
    logic [23:0] m1, m2;
    logic [1:0]  op;
    logic [26:0] exp_m2;
    int          exp_lat;
  } vec_t;

`ifdef FPU_ALIGN_EARLY_EXIT_EN
  localparam int LAT27 = 1;
`else
  localparam int LAT27 = 8;
`endif

  initial begin
    vec_t vecs[8];
    logic [26:0] hold_m2;
    int seen;

    // Reset state
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst mant2", out_mantissa_2, 0);
    chk("rst exp_op", {out_exponent, out_exponent_2, out_operator}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    vecs[0] = '{8'h80, 8'h80, 24'h800000, 24'h800000, 2'b00, 27'h4000000, 1};
    vecs[1] = '{8'h85, 8'h80, 24'hC00000, 24'h800000, 2'b00, 27'h0200000, 3};
    vecs[2] = '{8'h84, 8'h80, 24'h900000, 24'h800001, 2'b01, 27'h0400001, 2};
    vecs[3] = '{8'h9E, 8'h80, 24'hFFFFFF, 24'hFFFFFF, 2'b00, 27'h0000001, LAT27};
    vecs[4] = '{8'h8A, 8'h80, 24'h812345, 24'hABCDEF, 2'b10, 27'h55E6F78, 1};
    vecs[5] = '{8'h9B, 8'h80, 24'h800000, 24'h000000, 2'b01, 27'h0000000, LAT27};
    vecs[6] = '{8'h81, 8'h80, 24'hA00000, 24'h800001, 2'b01, 27'h2000004, 2};
    vecs[7] = '{8'h40, 8'h40, 24'h800000, 24'hFEDCBA, 2'b11, 27'h7F6E5D0, 1};
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), i[0], i[1], vecs[i].e1, vecs[i].e2, vecs[i].m1,
             vecs[i].m2, vecs[i].op, vecs[i].exp_m2, vecs[i].exp_lat, 0);

    // Backpressure: hold in DONE while upstream churns; nothing may be taken
    sign_1 = 1'b1; sign_2 = 1'b0; exponent_1 = 8'h85; exponent_2 = 8'h80;
    mantissa_1 = 24'hF00000; mantissa_2 = 24'h800000; operator = 2'b00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 20) begin @(negedge clk); seen++; end
    chk("bp valid", out_valid, 1);
    hold_m2 = 27'h0200000;
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      exponent_1 = 8'($urandom); mantissa_2 = 24'($urandom); operator = 2'($urandom);
      @(negedge clk);
      chk($sformatf("bp hold%0d", c),
          {out_valid, in_ready, out_mantissa_2, out_exponent, out_operator, out_sign_1},
          {1'b1, 1'b0, hold_m2, 8'h85, 2'b00, 1'b1});
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp xfer no_accept", {out_valid, in_ready}, 2'b01);
    @(negedge clk);
    chk("bp idle", {out_valid, in_ready}, 2'b01);

    // Reset two cycles into an 8-cycle shift (d = 26 in both builds)
    sign_1 = 1'b1; sign_2 = 1'b1; exponent_1 = 8'h9A; exponent_2 = 8'h80;
    mantissa_1 = 24'hFFFFFF; mantissa_2 = 24'hC00001; operator = 2'b01; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst state", {out_valid, in_ready}, 2'b01);
    chk("midrst outs", {out_mantissa_1, out_mantissa_2, out_exponent, out_exponent_2,
                        out_operator, out_sign_1, out_sign_2}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst no_output", seen, 0);

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  e1, e2;
      logic [23:0] m1, m2;
      logic [1:0]  op;
      e1 = 8'($urandom_range(0, 254));
      e2 = e1 - 8'($urandom_range(0, (e1 < 40) ? int'(e1) : 40));
      m1 = {1'b1, 23'($urandom)};
      m2 = ($urandom_range(0, 9) == 0) ? 24'h0 : {1'b1, 23'($urandom)};
      op = 2'($urandom);
      run_op($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), e1, e2, m1, m2, op,
             ref_align(m2, e1, e2, op), ref_lat(e1, e2, op), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_align.md
Name: fpu_align

Overview:
- Downstream neighbour of the unpack stage. Consumes its registered larger/smaller operand fields and aligns the smaller mantissa to the larger exponent.
- Alignment is a right shift by the exponent difference, with guard/round/sticky bits appended.
- Uses a multi-cycle iterative shifter with a valid/ready handshake on both sides. Feeds the add/sub mantissa stage.
- Mul/div operators bypass alignment.

Parameters:
- SHIFT_STEP, 4: max bits shifted per cycle in SHIFT state; legal range 1..27.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream operands valid
- in_ready  out  1  block can accept operands
- sign_1  in  1  larger-operand sign
- sign_2  in  1  smaller-operand sign
- exponent_1  in  8  larger exponent; upstream guarantees exponent_1 >= exponent_2
- exponent_2  in  8  smaller exponent
- mantissa_1  in  24  larger mantissa, hidden bit included
- mantissa_2  in  24  smaller mantissa, hidden bit included
- operator  in  2  00 add, 01 sub, 10 mul, 11 div
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- out_sign_1  out  1  registered sign_1
- out_sign_2  out  1  registered sign_2
- out_exponent  out  8  common exponent (exponent_1)
- out_exponent_2  out  8  registered exponent_2 (needed by mul/div)
- out_mantissa_1  out  27  {mantissa_1, 3'b000}
- out_mantissa_2  out  27  aligned {mantissa_2, G, R, S}
- out_operator  out  2  registered operator

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - All outputs and internal registers = 0; out_valid = 0.
  - Reset mid-shift or while DONE discards the operation; no output is produced for it.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are combinational from state.
- Accept = in_valid && in_ready. On the accept edge:
  - Capture all input fields. work = {mantissa_2, 3'b000}.
  - remaining = min(exponent_1 - exponent_2, 27), as an 8-bit unsigned subtract then saturate.
  - If operator[1] == 1 (mul/div): remaining forced to 0, no shift.
  - Next state = DONE if remaining == 0, else SHIFT.
- SHIFT state, each edge:
  - n = min(remaining, SHIFT_STEP).
  - work = (work >> n), with bit0 ORed with the OR of all bits shifted out (including the previous bit0).
  - remaining -= n.
  - Move to DONE when the new remaining == 0.
- Latency from accept edge to out_valid high:
  - 1 cycle when no shift.
  - Otherwise 1 + ceil(d/SHIFT_STEP) cycles, where d is the saturated difference.
- DONE state:
  - Outputs are held stable while out_ready is low, for an unbounded time.
  - When out_ready is high: transfer, state goes to IDLE, and out_valid falls on the next cycle.
- Throughput: one operation per (latency + 1) cycles. No new operand is accepted in the same cycle as an output transfer.
- in_valid while not in IDLE is ignored; upstream must hold its data until accepted.
- d >= 27 and mantissa_2 != 0: final out_mantissa_2 = 27'h0000001 (sticky only).
- out_exponent = exponent_1 for every operator.

Optional Feature:
- Macro: FPU_ALIGN_EARLY_EXIT_EN.
- Defined: when the saturated d == 27, the accept edge loads work = {26'b0, |mantissa_2} and goes directly to DONE. Latency is 1.
- Undefined: d == 27 iterates like any other shift, with latency 1 + ceil(27/SHIFT_STEP).
- Result values are identical in both builds.

Decomposition:
- Shared package fpu_pkg holds:
  - operator encodings OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - widths EXP_W=8, MANT_W=24, GRS_W=3, ALIGN_W=27;
  - MAX_ALIGN_SHIFT=27;
  - state enum align_state_t.
- One natural sub-module: fpu_sticky_shift, combinational.
  - Inputs: work and n. Outputs: shifted value with the sticky bit merged.
  - Instantiated once in fpu_align.

Test Plan:
- d = 0: add, exp 0x80/0x80, mantissa_2 0x800000 -> out_valid 1 cycle after accept; out_mantissa_2 27'h4000000.
- d = 5, STEP = 4: mantissa_2 0x800000 -> 27'h0200000, no sticky; latency 3 cycles.
- Sticky: d = 4, mantissa_2 0x800001 -> 27'h0400001.
- d = 30: mantissa_2 0xFFFFFF -> 27'h0000001.
  - Latency 8 without the macro, 1 with FPU_ALIGN_EARLY_EXIT_EN.
- Mul (operator 10), d = 10: out_mantissa_2 = {mantissa_2, 000} unshifted; latency 1; out_operator = 10.
- Backpressure: hold out_ready low 5 cycles in DONE while toggling in_valid and inputs -> outputs stable, in_ready 0, nothing accepted.
- Reset mid-operation: assert rst_n low 2 cycles into an 8-cycle shift -> immediate IDLE, all outputs 0, no out_valid afterwards.
